// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the FWFT register-file FIFO: turns wr/rd requests
// into storage write enable and addresses, and publishes occupancy and error flags.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] AF_L = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_L = (ADDR_WIDTH+1)'(AE_LEVEL);

    // One extra wrap bit per pointer distinguishes full from empty.
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
    logic                wr_ok, rd_ok;

    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                          (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);

    assign wr_ok  = wr & ~full;
    assign rd_ok  = rd & ~empty;
    // Gated by reset so storage is never written while the controller is held in reset.
    assign w_en   = wr_ok & rst_n;
    assign w_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign r_addr = rd_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            // A new error event on the same edge as clr_err keeps the flag set.
            overflow  <= (wr & full)  | (overflow  & ~clr_err);
            underflow <= (rd & empty) | (underflow & ~clr_err);
        end
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for the team's first-word-fall-through (FWFT) FIFO. It is the read/write management side that drives the 8x8 register-file storage.
- It turns producer write requests and consumer read requests into the storage write enable, write address and read address.
- It publishes full/empty, almost-full/almost-empty, occupancy count, and sticky overflow/underflow error flags.
- It sits between the producer/consumer handshake and the register-file storage. Read data comes straight from storage at r_addr (asynchronous read).

Parameters:
- ADDR_WIDTH, 3, storage address width; depth = 2**ADDR_WIDTH (8 entries).
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr  in  1  producer write request (data on storage w_data this cycle).
- rd  in  1  consumer read/pop request (consumes word currently at r_addr).
- clr_err  in  1  synchronous clear of sticky overflow/underflow.
- w_en  out  1  storage write enable (combinational).
- w_addr  out  ADDR_WIDTH  storage write address = wr_ptr[ADDR_WIDTH-1:0].
- r_addr  out  ADDR_WIDTH  storage read address = rd_ptr[ADDR_WIDTH-1:0].
- full  out  1  FIFO holds 2**ADDR_WIDTH words.
- empty  out  1  FIFO holds 0 words; r_data invalid.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  occupancy, 0..2**ADDR_WIDTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits (extra wrap bit).
  - overflow and underflow registers.
- Reset (rst_n low, asynchronous, any time, including mid-transfer):
  - wr_ptr=0, rd_ptr=0, overflow=0, underflow=0.
  - Outputs therefore read: empty=1, full=0, count=0, almost_empty=1, almost_full=0, w_addr=0, r_addr=0, w_en=0.
  - Storage contents are not cleared; they are don't-care.
- Flags are combinational from the registered pointers:
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ) and (low ADDR_WIDTH bits equal).
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Write accept: wr_ok = wr & ~full.
  - w_en = wr_ok, in the same cycle; storage captures w_data at w_addr on that edge.
  - wr_ptr increments on the edge.
- Read accept: rd_ok = rd & ~empty.
  - rd_ptr increments on the edge.
  - FWFT: while empty=0, the head word is already present at r_addr. After a pop, the next word appears one cycle later via the updated r_addr.
- Write-to-read latency: a word written into an empty FIFO makes empty deassert and becomes visible at r_addr on the cycle after the write edge.
- Simultaneous wr and rd:
  - Neither full nor empty: both accepted, count unchanged, both pointers advance.
  - Empty: write accepted, read rejected and underflow set.
  - Full: read accepted, write rejected and overflow set. No write-through when full.
- Wrap-around: pointers roll over naturally modulo 2**(ADDR_WIDTH+1). The address outputs wrap from 2**ADDR_WIDTH-1 to 0.
- Sticky errors:
  - overflow <= 1 on an edge where wr & full; underflow <= 1 on an edge where rd & empty.
  - clr_err=1 clears both on the edge.
  - If clr_err and a new error event occur on the same edge, set wins.
  - Rejected requests never move pointers.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, almost_empty=1, w_en=0, overflow=underflow=0.
- Write 0xA1..0xA8 on 8 consecutive cycles -> count steps 1..8; almost_full at count=6; full=1 after the 8th edge; w_addr wraps 7->0. A 9th write -> w_en=0, overflow=1, count stays 8.
- From full, pop 8 times -> r_addr reads 0..7 with data 0xA1..0xA8 in order; empty=1 after the 8th pop. A 9th rd -> underflow=1, rd_ptr unchanged. Then pulse clr_err -> both flags 0.
- Count=3, wr=rd=1 for 20 cycles -> count stays 3; pointers wrap twice; data order is preserved across the wrap.
- Empty with wr=rd=1 -> count=1, underflow=1, and 0xB5 is visible at r_addr the next cycle. Full with wr=rd=1 -> count=7, overflow=1.
- Assert rst_n=0 asynchronously mid-burst at count=5 -> flags and count go to reset values immediately, without waiting for a clock edge; operation restarts at addresses 0.
